// File: rtl/text_pkg.sv
// text_pkg: text-mode geometry and command decoder states shared by the text datapath
package text_pkg;
    localparam int TEXT_COLS   = 80;
    localparam int TEXT_ROWS   = 30;
    localparam int TEXT_ADDR_W = 12;
    typedef enum logic [1:0] {S_COL, S_ROW, S_CHAR} state_t;
endpackage

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: assembles column/row/char byte triples into text RAM writes
module uart_cmd_decoder
    import text_pkg::*;
#(
    parameter int COLS    = TEXT_COLS,
    parameter int ROWS    = TEXT_ROWS,
    parameter int ADDR_W  = TEXT_ADDR_W,
    parameter int TIMEOUT = 65536
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              err_range,
    output logic              err_timeout,
    output logic              busy
);
    localparam int CNT_W = $clog2(TIMEOUT);
    state_t state, state_n;
    logic [7:0] col_q, row_q;
    logic [CNT_W-1:0] cnt;
    logic expire, in_range, do_wr, do_err;
    assign busy = state != S_COL;
    always_comb begin
        in_range = int'(col_q) < COLS && int'(row_q) < ROWS;
        // an arriving byte always beats a timeout on the same cycle
        expire   = busy && !rx_valid && cnt == CNT_W'(TIMEOUT - 1);
        do_wr    = rx_valid && state == S_CHAR && in_range;
        do_err   = rx_valid && state == S_CHAR && !in_range;
        state_n  = state;
        if (rx_valid)
            state_n = state == S_COL ? S_ROW : state == S_ROW ? S_CHAR : S_COL;
        else if (expire)
            state_n = S_COL;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_COL;
            col_q       <= '0;
            row_q       <= '0;
            cnt         <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            err_range   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            wr_en       <= do_wr;
            err_range   <= do_err;
            err_timeout <= expire;
            cnt         <= (rx_valid || !busy || expire) ? '0 : cnt + 1'b1;
            col_q       <= (rx_valid && state == S_COL) ? rx_data : expire ? '0 : col_q;
            row_q       <= (rx_valid && state == S_ROW) ? rx_data : expire ? '0 : row_q;
            if (do_wr) begin
                wr_addr <= ADDR_W'(int'(row_q) * COLS + int'(col_q));
                wr_data <= rx_data;
            end
        end
    end
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder: directed and random byte streams checked against a command-level model
module tb_uart_cmd_decoder;
    localparam int COLS = 80, ROWS = 30, AW = 12, TO = 200;
    logic clk = 0, rst = 1, rx_valid = 0;
    logic [7:0] rx_data = 0;
    logic wr_en, err_range, err_timeout, busy;
    logic [AW-1:0] wr_addr;
    logic [7:0] wr_data;
    int n_chk = 0, n_fail = 0;

    uart_cmd_decoder #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .err_range(err_range), .err_timeout(err_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // command model: bytes collected so far plus idle cycles since the last byte
    int n_pend = 0, idle = 0;
    int pend[2];
    logic m_wr = 0, m_er = 0, m_et = 0, m_busy = 0;
    int m_addr = 0, m_data = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n_pend = 0; idle = 0; m_wr = 0; m_er = 0; m_et = 0; m_addr = 0; m_data = 0;
        end else begin
            m_wr = 0; m_er = 0; m_et = 0;
            if (rx_valid) begin
                idle = 0;
                if (n_pend < 2) begin
                    pend[n_pend] = int'(rx_data);
                    n_pend++;
                end else begin
                    if (pend[0] < COLS && pend[1] < ROWS) begin
                        m_wr = 1;
                        m_addr = (pend[1] * COLS + pend[0]) % (1 << AW);
                        m_data = int'(rx_data);
                    end else m_er = 1;
                    n_pend = 0;
                end
            end else if (n_pend > 0) begin
                idle++;
                if (idle == TO) begin
                    m_et = 1; n_pend = 0; idle = 0;
                end
            end
        end
        m_busy = n_pend > 0;
    end

    always @(negedge clk) if (!rst) begin
        chk("wr_en", 32'(wr_en), 32'(m_wr));
        chk("err_range", 32'(err_range), 32'(m_er));
        chk("err_timeout", 32'(err_timeout), 32'(m_et));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("wr_addr", 32'(wr_addr), 32'(m_addr));
        chk("wr_data", 32'(wr_data), 32'(m_data));
    end

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1;
        @(negedge clk);
        rx_valid = 0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset wr_en", 32'(wr_en), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset wr_addr", 32'(wr_addr), 0);
        rst = 0;
        @(negedge clk);
        send(17); send(29); send(8'h32);
        chk("s1 wr_en", 32'(wr_en), 1);
        chk("s1 wr_addr", 32'(wr_addr), 2337);
        chk("s1 wr_data", 32'(wr_data), 32'h32);
        @(negedge clk);
        chk("s1 pulse width", 32'(wr_en), 0);
        send(79); send(0);
        chk("s2 held addr", 32'(wr_addr), 2337);
        chk("s2 held data", 32'(wr_data), 32'h32);
        send(8'h39);
        chk("s2 wr_addr", 32'(wr_addr), 79);
        chk("s2 wr_data", 32'(wr_data), 32'h39);
        send(80); send(0); send(8'h41);
        chk("s3 col err", 32'(err_range), 1);
        chk("s3 col no wr", 32'(wr_en), 0);
        send(0); send(30); send(8'h41);
        chk("s3 row err", 32'(err_range), 1);
        send(0); send(29); send(8'h41);
        chk("s3 wr_addr", 32'(wr_addr), 2320);
        @(negedge clk);
        send(17);
        repeat (TO - 1) @(negedge clk);
        chk("s4 busy before", 32'(busy), 1);
        chk("s4 no early timeout", 32'(err_timeout), 0);
        @(negedge clk);
        chk("s4 err_timeout", 32'(err_timeout), 1);
        chk("s4 busy fell", 32'(busy), 0);
        send(5); send(2); send(8'h58);
        chk("s4 wr_addr", 32'(wr_addr), 165);
        chk("s4 wr_data", 32'(wr_data), 32'h58);
        send(10); send(10);
        rst = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        chk("s5 busy after rst", 32'(busy), 0);
        chk("s5 no wr", 32'(wr_en), 0);
        send(1); send(1); send(8'h5A);
        chk("s5 wr_addr", 32'(wr_addr), 81);
        chk("s5 wr_data", 32'(wr_data), 32'h5A);
        send(5);
        repeat (TO - 1) @(negedge clk);
        send(3);
        chk("s6 no timeout", 32'(err_timeout), 0);
        chk("s6 busy", 32'(busy), 1);
        send(8'h41);
        chk("s6 wr_addr", 32'(wr_addr), 245);
        for (int i = 0; i < 400; i++) begin
            int g;
            logic [7:0] b;
            g = ($urandom_range(0, 19) == 0) ? $urandom_range(TO - 2, TO + 20) : $urandom_range(0, 3);
            b = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 90));
            send(b);
            repeat (g) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
